// File: rtl/agp32_mem_pkg.sv
// agp32 data-memory bridge: shared command codes, completion status codes
// and the bridge FSM state type.
package agp32_mem_pkg;

  // Processor command codes (compared after resizing to CMD_WIDTH)
  localparam int CMD_NONE  = 0;
  localparam int CMD_READ  = 1;
  localparam int CMD_WRITE = 2;

  // Completion status returned on cpu_error
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_SLAVE   = 2'b01;
  localparam logic [1:0] ERR_BADCMD  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/agp32_irq_handshake.sv
// Interrupt request/acknowledge handshake.
// A rising edge on i_req sets a one-deep pending flag, which is presented
// as o_pending. i_ack while pending clears the flag and produces a
// one-cycle o_ack_pulse. A rising edge coincident with an ack keeps the
// flag set, so a freshly raised interrupt is never lost.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   i_req       interrupt request level from the processor
//   i_ack       acknowledge from the platform
//   o_pending   pending flag (drives the platform interrupt line)
//   o_ack_pulse one-cycle acknowledge pulse back to the processor
module agp32_irq_handshake (
  input  logic clk,
  input  logic rst,
  input  logic i_req,
  input  logic i_ack,
  output logic o_pending,
  output logic o_ack_pulse
);

  logic r_req_d;
  logic r_pending;
  logic r_ack_pulse;
  logic w_rise;

  assign w_rise = i_req & ~r_req_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_d     <= 1'b0;
      r_pending   <= 1'b0;
      r_ack_pulse <= 1'b0;
    end else begin
      r_req_d     <= i_req;
      r_ack_pulse <= i_ack & r_pending;
      // The new edge takes priority over the clear.
      if (w_rise)
        r_pending <= 1'b1;
      else if (i_ack)
        r_pending <= 1'b0;
    end
  end

  assign o_pending   = r_pending;
  assign o_ack_pulse = r_ack_pulse;

endmodule

// File: rtl/agp32_mem_bridge.sv
// Bridge from the agp32 command-style data-memory port to a valid/ready
// memory bus. One command is latched at a time, its address is forced to
// word alignment and a single bus request is issued. The response (or a
// timeout) completes the command with a one-cycle cpu_ready pulse; read
// data and status are held until the next completion. The interrupt
// handshake runs alongside, independent of the memory FSM.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cpu_command/addr/wdata/wstrb   processor command inputs
//   cpu_mem_start_ready       bridge idle, a command is accepted this cycle
//   cpu_ready                 one-cycle completion pulse
//   cpu_rdata, cpu_error      completion data/status (held)
//   cpu_interrupt_req/ack     processor interrupt handshake
//   mem_valid/ready/we/addr/wdata/wstrb   bus request channel
//   mem_rvalid/rdata/rerr     bus response channel
//   irq_out, irq_ack          platform interrupt line and acknowledge
module agp32_mem_bridge
  import agp32_mem_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ALIGN_BITS     = 2,
  parameter int CMD_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [CMD_WIDTH-1:0]    cpu_command,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
  output logic                    cpu_mem_start_ready,
  output logic                    cpu_ready,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic [1:0]              cpu_error,
  input  logic                    cpu_interrupt_req,
  output logic                    cpu_interrupt_ack,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_rerr,
  output logic                    irq_out,
  input  logic                    irq_ack
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                r_state;
  logic [15:0]           r_cnt;
  logic                  r_start_ready;
  logic                  r_cpu_ready;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [1:0]            r_cpu_error;
  logic                  r_mem_valid;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [STRB_W-1:0]     r_mem_wstrb;

  logic                  w_is_none;
  logic                  w_is_read;
  logic                  w_is_write;
  logic [ADDR_WIDTH-1:0] w_addr_mask;
  logic [1:0]            w_rsp_err;

  assign w_is_none   = (cpu_command == CMD_WIDTH'(CMD_NONE));
  assign w_is_read   = (cpu_command == CMD_WIDTH'(CMD_READ));
  assign w_is_write  = (cpu_command == CMD_WIDTH'(CMD_WRITE));
  assign w_addr_mask = ~ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  assign w_rsp_err   = mem_rerr ? ERR_SLAVE : ERR_OK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_start_ready <= 1'b1;
      r_cpu_ready   <= 1'b0;
      r_cpu_rdata   <= '0;
      r_cpu_error   <= ERR_OK;
      r_mem_valid   <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_wstrb   <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_is_read || w_is_write) begin
            r_mem_we      <= w_is_write;
            r_mem_addr    <= cpu_addr & w_addr_mask;
            r_mem_wdata   <= cpu_wdata;
            r_mem_wstrb   <= cpu_wstrb;
            r_start_ready <= 1'b0;
            // A write that enables no byte lanes is a no-op on the bus.
            if (w_is_write && (cpu_wstrb == '0)) begin
              r_state     <= ST_DONE;
              r_cpu_ready <= 1'b1;
              r_cpu_error <= ERR_OK;
            end else begin
              r_state     <= ST_REQ;
              r_mem_valid <= 1'b1;
            end
          end else if (!w_is_none) begin
            r_state       <= ST_DONE;
            r_start_ready <= 1'b0;
            r_cpu_ready   <= 1'b1;
            r_cpu_error   <= ERR_BADCMD;
          end
        end
        ST_REQ: begin
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_cnt       <= '0;
            // Response coincident with acceptance completes immediately.
            if (mem_rvalid) begin
              r_state     <= ST_DONE;
              r_cpu_ready <= 1'b1;
              r_cpu_error <= w_rsp_err;
              if (!r_mem_we)
                r_cpu_rdata <= mem_rdata;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            r_state     <= ST_DONE;
            r_cpu_ready <= 1'b1;
            r_cpu_error <= w_rsp_err;
            if (!r_mem_we)
              r_cpu_rdata <= mem_rdata;
          end else if (r_cnt == TO_LAST) begin
            // Completion lands exactly TIMEOUT_CYCLES cycles after entry.
            r_state     <= ST_DONE;
            r_cpu_ready <= 1'b1;
            r_cpu_error <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          r_state       <= ST_IDLE;
          r_start_ready <= 1'b1;
        end
        default: begin
          r_state       <= ST_IDLE;
          r_start_ready <= 1'b1;
          r_mem_valid   <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_mem_start_ready = r_start_ready;
  assign cpu_ready           = r_cpu_ready;
  assign cpu_rdata           = r_cpu_rdata;
  assign cpu_error           = r_cpu_error;
  assign mem_valid           = r_mem_valid;
  assign mem_we              = r_mem_we;
  assign mem_addr            = r_mem_addr;
  assign mem_wdata           = r_mem_wdata;
  assign mem_wstrb           = r_mem_wstrb;

  agp32_irq_handshake u_irq (
    .clk         (clk),
    .rst         (rst),
    .i_req       (cpu_interrupt_req),
    .i_ack       (irq_ack),
    .o_pending   (irq_out),
    .o_ack_pulse (cpu_interrupt_ack)
  );

endmodule

// File: tb/tb_agp32_mem_bridge.sv
module tb_agp32_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cpu_command;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wstrb;
  logic        cpu_mem_start_ready;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [1:0]  cpu_error;
  logic        cpu_interrupt_req;
  logic        cpu_interrupt_ack;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_rerr;
  logic        irq_out;
  logic        irq_ack;

  int n_vec = 0;
  int n_err = 0;

  agp32_mem_bridge #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (32),
    .ALIGN_BITS     (2),
    .CMD_WIDTH      (3),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cpu_command         (cpu_command),
    .cpu_addr            (cpu_addr),
    .cpu_wdata           (cpu_wdata),
    .cpu_wstrb           (cpu_wstrb),
    .cpu_mem_start_ready (cpu_mem_start_ready),
    .cpu_ready           (cpu_ready),
    .cpu_rdata           (cpu_rdata),
    .cpu_error           (cpu_error),
    .cpu_interrupt_req   (cpu_interrupt_req),
    .cpu_interrupt_ack   (cpu_interrupt_ack),
    .mem_valid           (mem_valid),
    .mem_ready           (mem_ready),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_wstrb           (mem_wstrb),
    .mem_rvalid          (mem_rvalid),
    .mem_rdata           (mem_rdata),
    .mem_rerr            (mem_rerr),
    .irq_out             (irq_out),
    .irq_ack             (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set afterwards are stable well before the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] cmd, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    cpu_command = cmd;
    cpu_addr    = a;
    cpu_wdata   = wd;
    cpu_wstrb   = ws;
    tick();
    cpu_command = 3'd0;
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    cpu_command = 3'd0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    cpu_interrupt_req = 1'b0; irq_ack = 1'b0;
    mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0; mem_rerr = 1'b0;
    tick(); tick();

    chk("rst_start_ready", cpu_mem_start_ready, 1);
    chk("rst_mem_valid",   mem_valid, 0);
    chk("rst_cpu_ready",   cpu_ready, 0);
    chk("rst_rdata",       cpu_rdata, 0);
    chk("rst_error",       cpu_error, 0);
    chk("rst_irq_out",     irq_out, 0);
    rst = 1'b0;
    tick();

    // Read 0x1003 with zero-wait memory
    issue(3'd1, 32'h0000_1003, 32'h0, 4'hF);
    chk("rd_valid", mem_valid, 1);
    chk("rd_addr",  mem_addr, 32'h0000_1000);
    chk("rd_we",    mem_we, 0);
    chk("rd_busy",  cpu_mem_start_ready, 0);
    tick();
    chk("rd_wait_valid", mem_valid, 0);
    chk("rd_wait_ready", cpu_ready, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("rd_cpu_ready", cpu_ready, 1);
    chk("rd_rdata",     cpu_rdata, 32'hDEAD_BEEF);
    chk("rd_error",     cpu_error, 0);
    tick();
    chk("rd_pulse_end", cpu_ready, 0);
    chk("rd_idle",      cpu_mem_start_ready, 1);

    // Write with request back-pressure: request stays stable for 6 cycles
    mem_ready = 1'b0;
    issue(3'd2, 32'h0000_0020, 32'h1234_5678, 4'h3);
    for (int i = 0; i < 6; i++) begin
      chk("wr_valid", mem_valid, 1);
      chk("wr_addr",  mem_addr, 32'h20);
      chk("wr_data",  mem_wdata, 32'h1234_5678);
      chk("wr_strb",  mem_wstrb, 4'h3);
      chk("wr_we",    mem_we, 1);
      if (i == 5) mem_ready = 1'b1;
      tick();
    end
    chk("wr_accepted", mem_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_rvalid = 1'b0;
    chk("wr_cpu_ready", cpu_ready, 1);
    chk("wr_error",     cpu_error, 0);
    chk("wr_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // Read with no response: timeout 8 cycles after entering WAIT
    issue(3'd1, 32'h0000_0040, 32'h0, 4'hF);
    tick();
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (cpu_ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    chk("to_latency",    lat, 8);
    chk("to_error",      cpu_error, 2'b11);
    chk("to_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("to_late_rvalid", cpu_ready, 0);
    end
    mem_rvalid = 1'b0;
    chk("to_late_rdata", cpu_rdata, 32'hDEAD_BEEF);

    // Slave error response
    issue(3'd1, 32'h0000_0080, 32'h0, 4'hF);
    tick();
    mem_rvalid = 1'b1; mem_rerr = 1'b1; mem_rdata = 32'h0000_0055;
    tick();
    mem_rvalid = 1'b0; mem_rerr = 1'b0;
    chk("serr_ready", cpu_ready, 1);
    chk("serr_error", cpu_error, 2'b01);
    tick();

    // Response coincident with acceptance
    issue(3'd1, 32'h0000_0106, 32'h0, 4'hF);
    chk("same_addr", mem_addr, 32'h0000_0104);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    chk("same_ready", cpu_ready, 1);
    chk("same_rdata", cpu_rdata, 32'hCAFE_F00D);
    chk("same_error", cpu_error, 2'b00);
    tick();

    // Unknown command
    issue(3'b101, 32'h0000_0200, 32'h0, 4'hF);
    chk("bad_ready", cpu_ready, 1);
    chk("bad_error", cpu_error, 2'b10);
    chk("bad_valid", mem_valid, 0);
    tick();
    chk("bad_valid2", mem_valid, 0);
    chk("bad_idle",   cpu_mem_start_ready, 1);

    // Write with no byte enables
    issue(3'd2, 32'h0000_0300, 32'hFFFF_FFFF, 4'h0);
    chk("z_ready", cpu_ready, 1);
    chk("z_error", cpu_error, 2'b00);
    chk("z_valid", mem_valid, 0);
    tick();
    chk("z_valid2", mem_valid, 0);

    // Interrupt handshake
    cpu_interrupt_req = 1'b1;
    tick();
    chk("irq_set", irq_out, 1);
    chk("irq_noack", cpu_interrupt_ack, 0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_ackpulse", cpu_interrupt_ack, 1);
    chk("irq_cleared",  irq_out, 0);
    tick();
    chk("irq_ack_end",  cpu_interrupt_ack, 0);
    chk("irq_level_no_reraise", irq_out, 0);
    cpu_interrupt_req = 1'b0;
    tick();
    cpu_interrupt_req = 1'b1;
    tick();
    cpu_interrupt_req = 1'b0;
    tick();
    chk("irq_pend2", irq_out, 1);
    cpu_interrupt_req = 1'b1; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    chk("irq_edge_wins", irq_out, 1);
    chk("irq_edge_ack",  cpu_interrupt_ack, 1);
    tick();
    chk("irq_still", irq_out, 1);

    // Asynchronous reset while a request is outstanding
    mem_ready = 1'b0;
    issue(3'd1, 32'h0000_0400, 32'h0, 4'hF);
    chk("rreq_valid", mem_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("rreq_valid_drop", mem_valid, 0);
    chk("rreq_start_ready", cpu_mem_start_ready, 1);
    chk("rreq_irq_clear", irq_out, 0);
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();

    // Asynchronous reset in WAIT, then a stray response
    issue(3'd1, 32'h0000_0500, 32'h0, 4'hF);
    tick();
    chk("rwait_busy", cpu_mem_start_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rwait_start_ready", cpu_mem_start_ready, 1);
    chk("rwait_valid", mem_valid, 0);
    chk("rwait_rdata_clr", cpu_rdata, 0);
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rwait_stray", cpu_ready, 0);
    end
    mem_rvalid = 1'b0;
    chk("rwait_rdata_kept", cpu_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/agp32_mem_bridge.md
Name: agp32_mem_bridge

Overview:
- Parametrised bridge between the agp32 processor's command-style data-memory port and a valid/ready memory bus.
- Latches one processor command, forces word alignment on the address and issues one bus request.
- Waits for the response with a timeout, then returns data and status to the processor.
- Also carries the processor's interrupt request/acknowledge handshake with a one-deep pending flag.

Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8.
- ADDR_WIDTH, 32, byte address width.
- ALIGN_BITS, 2, low address bits forced to zero; equals log2(DATA_WIDTH/8).
- CMD_WIDTH, 3, processor command width.
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a timeout; range 1..65535.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- cpu_command  in  CMD_WIDTH  command code; see package
- cpu_addr  in  ADDR_WIDTH  byte address
- cpu_wdata  in  DATA_WIDTH  write data
- cpu_wstrb  in  DATA_WIDTH/8  byte enables
- cpu_mem_start_ready  out  1  bridge idle, command can be accepted
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  read data, held until the next completion
- cpu_error  out  2  completion status, held until the next completion
- cpu_interrupt_req  in  1  processor raises interrupt (level)
- cpu_interrupt_ack  out  1  one-cycle pulse when the interrupt is serviced
- mem_valid  out  1  request valid
- mem_ready  in  1  request accepted
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_WIDTH  aligned address
- mem_wdata  out  DATA_WIDTH  write data
- mem_wstrb  out  DATA_WIDTH/8  byte enables
- mem_rvalid  in  1  response valid
- mem_rdata  in  DATA_WIDTH  response data
- mem_rerr  in  1  slave error flag on response
- irq_out  out  1  interrupt to the platform
- irq_ack  in  1  platform acknowledge

Behaviour:
- **Reset values:** all outputs 0 except cpu_mem_start_ready = 1. FSM goes to IDLE; rdata, error and timeout counter cleared.
- **FSM states:** IDLE, REQ, WAIT, DONE.
- **IDLE:**
  - cpu_mem_start_ready = 1.
  - cpu_command == CMD_NONE: stay in IDLE.
  - CMD_READ or CMD_WRITE: latch addr as {cpu_addr[ADDR_WIDTH-1:ALIGN_BITS], 0}, plus wdata and wstrb; go to REQ next cycle.
  - CMD_WRITE with wstrb == 0: no bus request; go straight to DONE with error 00.
  - Any other code: go to DONE with error = ERR_BADCMD (10), no bus request.
- **REQ:**
  - mem_valid = 1; mem_we, mem_addr, mem_wdata, mem_wstrb driven from the latched values and stable while valid.
  - Leave REQ on mem_valid & mem_ready: go to WAIT and clear the counter.
  - mem_rvalid arriving in the same cycle as acceptance counts as the response: go straight to DONE.
  - REQ has no timeout.
- **WAIT:**
  - Counter increments each cycle.
  - mem_rvalid: capture rdata (reads only; writes leave cpu_rdata unchanged); error = 01 if mem_rerr, else 00; go to DONE.
  - Counter reaches TIMEOUT_CYCLES: error = ERR_TIMEOUT (11), cpu_rdata unchanged, go to DONE.
  - mem_rvalid arriving after a timeout is ignored.
- **DONE:** cpu_ready = 1 for exactly one cycle; return to IDLE. cpu_mem_start_ready = 0 in REQ, WAIT and DONE.
- **Latency:** with zero-wait memory (mem_ready held 1, rvalid one cycle after accept), command in IDLE to cpu_ready is 4 cycles (IDLE→REQ→WAIT→DONE).
- **Interrupt path:**
  - Rising edge of cpu_interrupt_req sets pending.
  - irq_out = pending.
  - irq_ack while pending clears pending and pulses cpu_interrupt_ack for one cycle.
  - A rising edge in the same cycle as an ack leaves pending set; the edge wins over the clear.
  - The interrupt path is independent of the memory FSM.
- **Reset mid-operation:** asynchronous return to reset values, including dropping mem_valid. Any bus response after reset is ignored; the bridge is in IDLE and rvalid is ignored outside WAIT/REQ.

Decomposition:
- Package agp32_mem_pkg holds:
  - Command constants: CMD_NONE = 0, CMD_READ = 1, CMD_WRITE = 2.
  - Error constants: ERR_OK = 00, ERR_SLAVE = 01, ERR_BADCMD = 10, ERR_TIMEOUT = 11.
  - The FSM state enum.
- Sub-module agp32_irq_handshake: edge detect, pending flag and ack pulse. Instantiated once; everything else is top-level.

Test Plan:
- Read 0x0000_1003, mem_ready = 1, rvalid one cycle later with rdata 0xDEADBEEF → mem_addr = 0x0000_1000, mem_we = 0, cpu_ready pulse on cycle 4, cpu_rdata = 0xDEADBEEF, cpu_error = 00.
- Write 0x20 with wdata 0x12345678, wstrb 0x3, mem_ready held low 5 cycles → mem_valid, addr and data stable for 6 cycles; completion error 00; cpu_rdata keeps its previous value.
- Read with no rvalid, TIMEOUT_CYCLES = 8 → cpu_ready exactly 8 cycles after entering WAIT, error = 11; a later rvalid produces no second cpu_ready.
- Response with mem_rerr = 1 → error = 01. Command 3'b101 → error = 10, mem_valid never asserted. Write with wstrb = 0 → error = 00, no mem_valid.
- cpu_interrupt_req rises → irq_out = 1 next cycle; irq_ack → cpu_interrupt_ack pulses once and irq_out drops. New rising edge coincident with an ack → irq_out stays 1.
- Assert rst while in WAIT → mem_valid = 0, cpu_mem_start_ready = 1 immediately; a subsequent rvalid produces no cpu_ready.
